// File: rtl/module_operand_entry_pkg.sv
// Shared calculator definitions: keypad codes and the operand-entry state set.
// Imported by every block that decodes keys or tracks operand entry.
package module_operand_entry_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/module_operand_entry.sv
// Collects up to MAX_DIGITS BCD digits per operand from a debounced keypad and
// strobes operand A, then operand B, to the downstream arithmetic block.
module module_operand_entry
    import module_operand_entry_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] bcd_out,
    output logic       load_a,
    output logic       load_b,
    output logic [1:0] digit_cnt,
    output logic       ops_ready
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_bcd, w_bcd_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic       r_load_a, w_load_a_nxt;
    logic       r_load_b, w_load_b_nxt;
    logic       r_ready, w_ready_nxt;
    logic       w_busy;

    // The cycle after any strobe is spent clearing the operand; keys there are dropped.
    assign w_busy = r_load_a | r_load_b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ENTER_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (r_load_a) begin
            w_state_nxt = ENTER_B;
        end else if (r_load_b) begin
            w_state_nxt = DONE;
        end else if (key_valid && key_code == KEY_CLEAR) begin
            w_state_nxt = ENTER_A;
        end
    end

    always_comb begin
        w_bcd_nxt    = r_bcd;
        w_cnt_nxt    = r_cnt;
        w_ready_nxt  = r_ready;
        w_load_a_nxt = 1'b0;
        w_load_b_nxt = 1'b0;
        if (w_busy) begin
            w_bcd_nxt = 8'h00;
            w_cnt_nxt = 2'd0;
            if (r_load_b) begin
                w_ready_nxt = 1'b1;
            end
        end else if (key_valid) begin
            if (key_code == KEY_CLEAR) begin
                w_bcd_nxt   = 8'h00;
                w_cnt_nxt   = 2'd0;
                w_ready_nxt = 1'b0;
            end else if (key_code == KEY_ENTER && r_state != DONE) begin
                w_load_a_nxt = (r_state == ENTER_A);
                w_load_b_nxt = (r_state == ENTER_B);
            end else if (is_digit(key_code) && r_state != DONE && r_cnt < MAX_CNT) begin
                w_bcd_nxt = {r_bcd[3:0], key_code};
                w_cnt_nxt = r_cnt + 2'd1;
            end
        end
    end

    // All outputs come straight from flops; the comb block above only forms their next values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd    <= 8'h00;
            r_cnt    <= 2'd0;
            r_load_a <= 1'b0;
            r_load_b <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_bcd    <= w_bcd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_load_a <= w_load_a_nxt;
            r_load_b <= w_load_b_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign bcd_out   = r_bcd;
    assign digit_cnt = r_cnt;
    assign load_a    = r_load_a;
    assign load_b    = r_load_b;
    assign ops_ready = r_ready;

endmodule

// File: tb/tb_module_operand_entry.sv
// Self-checking bench for module_operand_entry: a decimal-value reference model
// predicts strobes into a scoreboard queue and per-cycle register values.
module tb_module_operand_entry;

    localparam int MAX_DIGITS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] bcd_out;
    logic       load_a;
    logic       load_b;
    logic [1:0] digit_cnt;
    logic       ops_ready;

    module_operand_entry #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .bcd_out   (bcd_out),
        .load_a    (load_a),
        .load_b    (load_b),
        .digit_cnt (digit_cnt),
        .ops_ready (ops_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_b;
        logic [7:0] value;
    } strobe_t;
    strobe_t sb_q[$];

    // Reference model: operand kept as a plain decimal number.
    int m_phase;   // 0 = entering A, 1 = entering B, 2 = both loaded
    int m_val;
    int m_cnt;
    bit m_ready;
    bit m_in_load;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_val     = 0;
        m_cnt     = 0;
        m_ready   = 0;
        m_in_load = 0;
        sb_q.delete();
    endtask

    // Effect of one clock edge given the key presented in that cycle.
    task automatic model_step(input bit v, input logic [3:0] code);
        if (m_in_load) begin
            m_in_load = 0;
            m_val     = 0;
            m_cnt     = 0;
            m_phase   = m_phase + 1;
            if (m_phase == 2) m_ready = 1;
        end else if (v) begin
            if (code == 4'hB) begin
                m_phase = 0;
                m_val   = 0;
                m_cnt   = 0;
                m_ready = 0;
            end else if (code == 4'hA && m_phase < 2) begin
                sb_q.push_back('{is_b: (m_phase == 1), value: to_bcd(m_val)});
                m_in_load = 1;
            end else if (code <= 4'd9 && m_phase < 2 && m_cnt < MAX_DIGITS) begin
                m_val = m_val * 10 + int'(code);
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".bcd_out"},   bcd_out,          to_bcd(m_val));
        check({tag, ".digit_cnt"}, {6'd0, digit_cnt}, 8'(m_cnt));
        check({tag, ".ops_ready"}, {7'd0, ops_ready}, {7'd0, m_ready});
        check({tag, ".load_a"},    {7'd0, load_a},    {7'd0, m_in_load && m_phase == 0});
        check({tag, ".load_b"},    {7'd0, load_b},    {7'd0, m_in_load && m_phase == 1});
    endtask

    // Drive one cycle from a negedge; compare at the following negedge.
    task automatic tick(input bit v, input logic [3:0] code, input string tag);
        key_valid = v;
        key_code  = code;
        model_step(v, code);
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        check_outputs(tag);
    endtask

    // Monitor: every strobe the DUT presents must match the oldest predicted one.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (load_a === 1'b1 && load_b === 1'b1) begin
                check("strobe_exclusive", {6'd0, load_a, load_b}, 8'h00);
            end
            if (load_a === 1'b1 || load_b === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", {6'd0, load_a, load_b}, 8'h00);
                end else begin
                    strobe_t exp_s;
                    exp_s = sb_q.pop_front();
                    check("strobe_is_b",  {7'd0, load_b}, {7'd0, exp_s.is_b});
                    check("strobe_value", bcd_out,        exp_s.value);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset_hold");
        rst = 1'b0;

        // Keys 4,2,enter then the clearing cycle.
        tick(1, 4'h4, "d4");
        tick(1, 4'h2, "d2");
        tick(1, 4'hA, "enter_a");
        tick(0, 4'h0, "after_a");

        // Operand B 1,9,5: third digit dropped; a key during the strobe is dropped.
        tick(1, 4'h1, "b1");
        tick(1, 4'h9, "b9");
        tick(1, 4'h5, "b5_ignored");
        tick(1, 4'hA, "enter_b");
        tick(1, 4'h3, "key_in_load");
        tick(0, 4'h0, "done");
        tick(1, 4'h6, "done_digit");
        tick(1, 4'hA, "done_enter");
        tick(1, 4'hE, "done_unused");

        // Clear from DONE, then 3,clear,8,enter.
        tick(1, 4'hB, "clear_done");
        tick(1, 4'h3, "c3");
        tick(1, 4'hB, "clear_mid");
        tick(1, 4'h8, "c8");
        tick(1, 4'hA, "enter_08");
        tick(0, 4'h0, "after_08");

        // Empty operand and unused codes.
        tick(1, 4'hB, "clear2");
        tick(1, 4'hE, "unused_a");
        tick(1, 4'hA, "enter_empty");
        tick(1, 4'hC, "unused_load");
        tick(1, 4'hF, "unused_b");

        // Reset asserted between edges during a load_a cycle.
        tick(1, 4'hB, "clear3");
        tick(1, 4'h7, "r7");
        tick(1, 4'hA, "r_enter");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("reset_in_load");
        @(negedge clk);
        check_outputs("reset_in_load_hold");
        rst = 1'b0;
        tick(1, 4'h5, "post_reset_digit");
        tick(1, 4'hA, "post_reset_enter");
        tick(0, 4'h0, "post_reset_clr");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit         v;
            int         r;
            logic [3:0] c;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 60)      c = 4'($urandom_range(0, 9));
            else if (r < 78) c = 4'hA;
            else if (r < 86) c = 4'hB;
            else             c = 4'($urandom_range(12, 15));
            tick(v, c, "rand");
        end

        tick(0, 4'h0, "drain");
        check("scoreboard_empty", 8'(sb_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
